// File: rtl/regfile_writeback.sv
// Register file writeback: round-robin ALU/load arbitration, load formatting, registered write port.
// Define WB_LOAD_EXT_EN for sub-word load formatting and load-format error checking.
module regfile_writeback #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic              wrt_en,
  output logic [REG_AW-1:0] oprd,
  output logic [XLEN-1:0]   wrt_data,
  output logic              wb_err
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              err;
  } wb_req_t;

  logic            run;
  logic            grant_alu;
  logic            grant_ld;
  logic            accept;
  logic            last_ld;
  logic [XLEN-1:0] ld_fmt;
  logic            ld_err;
  wb_req_t         req;

  // Ties go to whichever side was not granted last; reset favours load.
  assign run       = !rst && !wb_stall;
  assign grant_ld  = run && ld_valid
                   && (!alu_valid || !last_ld);
  assign grant_alu = run && alu_valid
                   && (!ld_valid || last_ld);
  assign accept    = grant_ld || grant_alu;

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        err_q;

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_off)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      2'd3: ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16]
                        : ld_rdata[15:0];
  end

  always_comb begin
    ld_fmt = ld_rdata;
    ld_err = 1'b0;
    case (ld_funct3)
      3'b000: ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_err = ld_off[0];
      end
      3'b010: ld_err = |ld_off;
      3'b100: ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101: begin
        ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
        ld_err = ld_off[0];
      end
      default: ld_err = 1'b1;
    endcase
  end

  // Sticky until reset; any malformed accepted load counts, even to x0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (grant_ld && ld_err) begin
      err_q <= 1'b1;
    end
  end

  assign wb_err = err_q;
`else
  logic unused_fmt;

  assign ld_fmt     = ld_rdata;
  assign ld_err     = 1'b0;
  assign wb_err     = 1'b0;
  assign unused_fmt = ^{ld_funct3, ld_off};
`endif

  always_comb begin
    req = '0;
    unique case (1'b1)
      grant_ld: begin
        req.rd   = ld_rd;
        req.data = ld_fmt;
        req.err  = ld_err;
      end
      grant_alu: begin
        req.rd   = alu_rd;
        req.data = alu_data;
        req.err  = 1'b0;
      end
      default: req = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrt_en   <= 1'b0;
      oprd     <= '0;
      wrt_data <= '0;
      last_ld  <= 1'b0;
    end else begin
      wrt_en <= accept && (req.rd != '0) && !req.err;
      if (accept) begin
        oprd     <= req.rd;
        wrt_data <= req.data;
        last_ld  <= grant_ld;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback.
// Expected load formatting follows WB_LOAD_EXT_EN when defined.
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        wb_stall;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] ld_rdata;
  logic        wrt_en;
  logic [4:0]  oprd;
  logic [31:0] wrt_data;
  logic        wb_err;

  int n_chk;
  int n_fail;

  regfile_writeback #(.XLEN(32), .REG_AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_stall  (wb_stall),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_funct3 (ld_funct3),
    .ld_off    (ld_off),
    .ld_rdata  (ld_rdata),
    .wrt_en    (wrt_en),
    .oprd      (oprd),
    .wrt_data  (wrt_data),
    .wb_err    (wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  v_f3  [4];
  logic [1:0]  v_off [4];
  logic [31:0] v_exp [4];
  logic        err_exp;
  logic        we_exp;

  initial begin
    n_chk = 0;
    n_fail = 0;
    v_f3[0] = 3'b000; v_off[0] = 2'd1;
    v_f3[1] = 3'b000; v_off[1] = 2'd3;
    v_f3[2] = 3'b101; v_off[2] = 2'd2;
    v_f3[3] = 3'b001; v_off[3] = 2'd2;
`ifdef WB_LOAD_EXT_EN
    v_exp[0] = 32'h0000007F;
    v_exp[1] = 32'hFFFFFF80;
    v_exp[2] = 32'h000080FF;
    v_exp[3] = 32'hFFFF80FF;
    err_exp  = 1'b1;
    we_exp   = 1'b0;
`else
    for (int i = 0; i < 4; i++) v_exp[i] = 32'h80FF7F01;
    err_exp  = 1'b0;
    we_exp   = 1'b1;
`endif

    rst = 1'b1;
    wb_stall = 1'b0;
    alu_valid = 1'b0;
    alu_rd = '0;
    alu_data = '0;
    ld_valid = 1'b0;
    ld_rd = '0;
    ld_funct3 = 3'b010;
    ld_off = '0;
    ld_rdata = '0;
    #2;
    chk("rst_wrt_en", 32'(wrt_en), 0);
    chk("rst_oprd", 32'(oprd), 0);
    chk("rst_wrt_data", wrt_data, 0);
    chk("rst_wb_err", 32'(wb_err), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'd9;
    #1;
    chk("alu_ready", 32'(alu_ready), 1);
    chk("alu_ld_ready", 32'(ld_ready), 0);
    tick();
    alu_valid = 1'b0;
    chk("alu_wrt_en", 32'(wrt_en), 1);
    chk("alu_oprd", 32'(oprd), 6);
    chk("alu_data", wrt_data, 9);
    tick();
    chk("alu_idle_wrt_en", 32'(wrt_en), 0);
    chk("alu_idle_oprd", 32'(oprd), 6);

    // Tie: alternation starting with load
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd11;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_funct3 = 3'b010;
    ld_off = 2'd0; ld_rdata = 32'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_ld_ready", 32'(ld_ready), 32'(i % 2 == 0));
      chk("tie_alu_ready", 32'(alu_ready), 32'(i % 2 == 1));
      tick();
      chk("tie_wrt_en", 32'(wrt_en), 1);
      chk("tie_oprd", 32'(oprd), (i % 2 == 0) ? 8 : 5);
      chk("tie_data", wrt_data, (i % 2 == 0) ? 7 : 11);
    end
    alu_valid = 1'b0;
    ld_valid = 1'b0;

    // Load formatting
    ld_valid = 1'b1; ld_rd = 5'd9; ld_rdata = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      ld_funct3 = v_f3[i];
      ld_off = v_off[i];
      #1;
      chk("fmt_ld_ready", 32'(ld_ready), 1);
      tick();
      chk("fmt_wrt_en", 32'(wrt_en), 1);
      chk("fmt_data", wrt_data, v_exp[i]);
    end
    ld_valid = 1'b0;
    tick();

    // x0 write consumed without effect
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd5;
    #1;
    chk("x0_ready", 32'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    chk("x0_wrt_en", 32'(wrt_en), 0);
    chk("x0_wb_err", 32'(wb_err), 0);

    // Misaligned LW
    ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010;
    ld_off = 2'd2; ld_rdata = 32'h1234;
    #1;
    chk("err_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 1'b0;
    chk("err_wrt_en", 32'(wrt_en), 32'(we_exp));
    chk("err_wb_err", 32'(wb_err), 32'(err_exp));
    tick();
    tick();
    chk("err_held", 32'(wb_err), 32'(err_exp));

    // ALU grant so the next tie favours load
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0;
    chk("pre_stall_oprd", 32'(oprd), 7);

    // Stall with both valid
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd11;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_off = 2'd0;
    ld_rdata = 32'd7;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_alu_ready", 32'(alu_ready), 0);
      chk("stall_ld_ready", 32'(ld_ready), 0);
      tick();
      chk("stall_wrt_en", 32'(wrt_en), 0);
    end
    wb_stall = 1'b0;
    #1;
    chk("release_ld_ready", 32'(ld_ready), 1);
    chk("release_alu_ready", 32'(alu_ready), 0);
    tick();
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    chk("release_oprd", 32'(oprd), 8);
    chk("release_data", wrt_data, 7);

    // Async reset with a write pending
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hAB;
    tick();
    chk("pend_wrt_en", 32'(wrt_en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wrt_en", 32'(wrt_en), 0);
    chk("arst_oprd", 32'(oprd), 0);
    chk("arst_data", wrt_data, 0);
    chk("arst_wb_err", 32'(wb_err), 0);
    chk("arst_alu_ready", 32'(alu_ready), 0);
    alu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_wrt_en", 32'(wrt_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback unit for the RV32I core: the write-side counterpart of `register`. It accepts completed results from the ALU and load paths over valid/ready handshakes, arbitrates them round-robin, formats load data (byte/halfword select, sign/zero extension), and drives the register file write port (`wrt_en`, `oprd`, `wrt_data`) from a registered output stage. Writes to x0 are consumed but never issued. It also flags illegal or misaligned load formats.

## Interface
- `XLEN`, 32: data width.
- `REG_AW`, 5: register index width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_stall`  in  1  when high, no grants; output stage issues no write.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  REG_AW  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `ld_valid`  in  1  load result available.
- `ld_ready`  out  1  load result accepted this cycle.
- `ld_rd`  in  REG_AW  load destination register.
- `ld_funct3`  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `ld_off`  in  2  byte offset of the load address.
- `ld_rdata`  in  XLEN  raw aligned memory word.
- `wrt_en`  out  1  register file write enable.
- `oprd`  out  REG_AW  register file write index.
- `wrt_data`  out  XLEN  register file write data.
- `wb_err`  out  1  sticky error flag.

## Operation
- Grant is combinational: `alu_ready` = grant_alu, `ld_ready` = grant_ld; both are 0 while `rst` or `wb_stall` is high.
- Single requester valid: that requester is granted.
- Both valid: the requester not granted last is granted (`last_ld` flag). `last_ld` updates only on a grant; reset value 0, so the first tie goes to load.
- An accepted transaction (valid && ready) loads the output stage on the same edge: `oprd` = rd, `wrt_data` = formatted data, `wrt_en` = (rd != 0) && !err_cond.
- In cycles with no accepted transaction, `wrt_en` is 0 on the next edge; `oprd`/`wrt_data` hold their values.
- Load formatting: LB/LBU select byte `ld_off`; LH/LHU select halfword `ld_off[1]`; LW passes the word through. LB/LH sign-extend; LBU/LHU zero-extend.
- err_cond on an accepted load: funct3 in {011, 110, 111}; LH/LHU with `ld_off[0]`=1; or LW with `ld_off` != 0. The transaction is consumed, the write is suppressed, and `wb_err` is set. It stays set until reset.
- rd = 0: the transaction is consumed (ready asserted), `wrt_en` = 0, and no error is raised.

## Timing
- Latency: accepted at edge N → `wrt_en`/`oprd`/`wrt_data` valid during cycle N+1 → the register file commits at edge N+2's sampling point per its own write timing.
- Throughput: one write per cycle. The ALU is never starved for more than one cycle while it is valid.
- Reset (async): `wrt_en` = 0, `oprd` = 0, `wrt_data` = 0, `wb_err` = 0, `last_ld` = 0. The readies drop immediately.
- Reset asserted with an output write pending: the write is dropped (`wrt_en` cleared asynchronously).
- `wb_stall` asserted: no grants; the next-edge `wrt_en` is 0; `last_ld` holds.
- A requester must hold valid and its payload stable until ready. Dropping valid before ready is permitted and discards the request.

## Configuration
- `WB_LOAD_EXT_EN` defined: full load formatting and load-format error checking as above.
- Undefined: `ld_rdata` is written unmodified regardless of `ld_funct3`/`ld_off`. `wb_err` is tied to 0. Only LW-capable cores use this build.

## Test plan
- ALU only: `alu_valid`=1, rd=6, data=9 → `alu_ready`=1 same cycle; next cycle `wrt_en`=1, `oprd`=6, `wrt_data`=9; the following cycle `wrt_en`=0.
- Tie: both valid for 4 cycles, ALU rd=5/data=11, load rd=8 LW data=7 → grants alternate ld, alu, ld, alu; writes alternate 8:7, 5:11.
- Load extension: `ld_rdata`=0x80FF7F01, LB off=1 → 0x0000007F; LB off=3 → 0xFFFFFF80; LHU off=2 → 0x000080FF; LH off=2 → 0xFFFF80FF.
- x0 and error: ALU rd=0 data=5 → ready=1, `wrt_en` stays 0, `wb_err`=0. LW off=2 rd=3 → consumed, `wrt_en`=0, `wb_err`=1 and held.
- Stall: `wb_stall`=1 with both valid → both readies 0, `wrt_en`=0. Release → load granted first.
- Async reset mid-write: accept rd=4, assert `rst` during cycle N+1 → `wrt_en`, `oprd`, `wrt_data`, `wb_err` all 0 immediately, without waiting for an edge.
